// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// Routes a valid/ready input stream to one of two valid/ready output ports.
// The route for each beat is chosen by sel_a (1 = port A, 0 = port B).
// Each output port is backed by a one-entry register, so the output data and
// valid are always driven from flops. A port can be drained and reloaded in
// the same cycle, which sustains one beat per cycle per port. Each port also
// has an 8-bit wrapping counter of the beats it has delivered.
//
// Ports
//   clk          : single clock; all state updates on the rising edge
//   rst          : synchronous, active-high reset
//   in_data      : input beat payload (WIDTH bits)
//   in_valid     : an input beat is offered
//   in_ready     : the offered beat is accepted this cycle (0 during reset)
//   sel_a        : route of the offered beat, 1 = port A, 0 = port B
//   out_a_data   : port A payload
//   out_a_valid  : port A holds a beat
//   out_a_ready  : port A sink accepts the beat
//   out_b_data   : port B payload
//   out_b_valid  : port B holds a beat
//   out_b_ready  : port B sink accepts the beat
//   cnt_a, cnt_b : beats delivered on port A / port B, wrapping 255 -> 0
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel_a,
    output logic [WIDTH-1:0] out_a_data,
    output logic             out_a_valid,
    input  logic             out_a_ready,
    output logic [WIDTH-1:0] out_b_data,
    output logic             out_b_valid,
    input  logic             out_b_ready,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
);

    logic             a_vld_q, a_vld_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic             b_vld_q, b_vld_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic [7:0]       cnt_a_q, cnt_a_d;
    logic [7:0]       cnt_b_q, cnt_b_d;

    logic a_free, b_free;
    logic accept;
    logic load_a, load_b;
    logic drain_a, drain_b;

    // Wrapping beat counter; the 8-bit add wraps 255 -> 0 naturally.
    function automatic logic [7:0] count_step(input logic [7:0] cnt, input logic inc);
        return inc ? cnt + 8'd1 : cnt;
    endfunction

    // A port can take a new beat when it is empty or is being drained this
    // cycle. Only the selected port's state matters, and in_valid is not used,
    // so in_ready carries no combinational dependence on the source's valid.
    always_comb begin
        a_free   = !a_vld_q || out_a_ready;
        b_free   = !b_vld_q || out_b_ready;
        in_ready = !rst && (sel_a ? a_free : b_free);
        accept   = in_valid && in_ready;
        load_a   = accept && sel_a;
        load_b   = accept && !sel_a;
        drain_a  = a_vld_q && out_a_ready;
        drain_b  = b_vld_q && out_b_ready;
    end

    // Next state: a load wins over a drain so a simultaneous drain and load
    // keeps the port valid with the new beat.
    always_comb begin
        a_vld_d  = a_vld_q;
        a_data_d = a_data_q;
        b_vld_d  = b_vld_q;
        b_data_d = b_data_q;

        if (drain_a) a_vld_d = 1'b0;
        if (load_a) begin
            a_vld_d  = 1'b1;
            a_data_d = in_data;
        end

        if (drain_b) b_vld_d = 1'b0;
        if (load_b) begin
            b_vld_d  = 1'b1;
            b_data_d = in_data;
        end

        cnt_a_d = count_step(cnt_a_q, drain_a);
        cnt_b_d = count_step(cnt_b_q, drain_b);
    end

    // Reset discards held beats and clears the counters; no delivery is
    // counted in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q  <= 1'b0;
            a_data_q <= '0;
            b_vld_q  <= 1'b0;
            b_data_q <= '0;
            cnt_a_q  <= 8'd0;
            cnt_b_q  <= 8'd0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_data_q <= a_data_d;
            b_vld_q  <= b_vld_d;
            b_data_q <= b_data_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
        end
    end

    assign out_a_valid = a_vld_q;
    assign out_a_data  = a_data_q;
    assign out_b_valid = b_vld_q;
    assign out_b_data  = b_data_q;
    assign cnt_a       = cnt_a_q;
    assign cnt_b       = cnt_b_q;

endmodule

// File: tb/tb_stream_demux.sv
// -----------------------------------------------------------------------------
// tb_stream_demux
//
// Directed scenarios followed by a randomized run. A reference model keeps
// each output port as a queue of pending beats plus the last payload shown,
// and the delivery counts as integers taken modulo 256.
// -----------------------------------------------------------------------------
module tb_stream_demux;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         sel_a;
    logic [W-1:0] out_a_data;
    logic         out_a_valid;
    logic         out_a_ready;
    logic [W-1:0] out_b_data;
    logic         out_b_valid;
    logic         out_b_ready;
    logic [7:0]   cnt_a;
    logic [7:0]   cnt_b;

    stream_demux #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel_a       (sel_a),
        .out_a_data  (out_a_data),
        .out_a_valid (out_a_valid),
        .out_a_ready (out_a_ready),
        .out_b_data  (out_b_data),
        .out_b_valid (out_b_valid),
        .out_b_ready (out_b_ready),
        .cnt_a       (cnt_a),
        .cnt_b       (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    int           dlv_a  = 0;
    int           dlv_b  = 0;
    bit           m_acc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        if (rst) return 1'b0;
        if (sel_a) return (qa.size() == 0) || out_a_ready;
        return (qb.size() == 0) || out_b_ready;
    endfunction

    task automatic check_model();
        chk("in_ready",    32'(in_ready),    32'(model_ready()));
        chk("out_a_valid", 32'(out_a_valid), 32'(qa.size() != 0));
        chk("out_a_data",  32'(out_a_data),  32'(last_a));
        chk("out_b_valid", 32'(out_b_valid), 32'(qb.size() != 0));
        chk("out_b_data",  32'(out_b_data),  32'(last_b));
        chk("cnt_a",       32'(cnt_a),       32'(dlv_a));
        chk("cnt_b",       32'(cnt_b),       32'(dlv_b));
    endtask

    task automatic model_edge();
        bit acc;
        acc = in_valid && model_ready();
        if (rst) begin
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
            dlv_a  = 0;
            dlv_b  = 0;
        end else begin
            if (qa.size() != 0 && out_a_ready) begin
                void'(qa.pop_front());
                dlv_a = (dlv_a + 1) % 256;
            end
            if (qb.size() != 0 && out_b_ready) begin
                void'(qb.pop_front());
                dlv_b = (dlv_b + 1) % 256;
            end
            if (acc) begin
                if (sel_a) begin
                    qa.push_back(in_data);
                    last_a = in_data;
                end else begin
                    qb.push_back(in_data);
                    last_b = in_data;
                end
            end
        end
        m_acc = acc;
    endtask

    // Check current outputs against the model, advance one clock, and land
    // 1 time unit after the rising edge.
    task automatic tick();
        #1;
        check_model();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d,
                         input bit ar, input bit br);
        in_valid    = v;
        sel_a       = s;
        in_data     = d;
        out_a_ready = ar;
        out_b_ready = br;
    endtask

    int cb_start;
    int ca_start;

    initial begin
        drive(0, 0, '0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_edge();

        // Reset holds everything at zero and refuses input
        drive(1, 1, 8'hEE, 1, 1);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rst_a_valid", 32'(out_a_valid), 32'd0);
        chk("rst_b_data",  32'(out_b_data),  32'd0);
        chk("rst_cnt_a",   32'(cnt_a),       32'd0);
        rst = 1'b0;
        drive(0, 1, 8'h00, 0, 0);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Route to A
        drive(1, 1, 8'h5A, 1, 0);
        tick();
        drive(0, 1, 8'h00, 1, 0);
        chk("routeA_valid", 32'(out_a_valid), 32'd1);
        chk("routeA_data",  32'(out_a_data),  32'h5A);
        chk("routeA_bvld",  32'(out_b_valid), 32'd0);
        tick();
        chk("routeA_cnt",   32'(cnt_a),       32'd1);

        // Backpressure on B
        drive(1, 0, 8'h11, 0, 0);
        tick();
        drive(1, 0, 8'h22, 0, 0);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("bp_hold_data", 32'(out_b_data), 32'h11);
        out_b_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_second_data", 32'(out_b_data),  32'h22);
        chk("bp_second_vld",  32'(out_b_valid), 32'd1);
        chk("bp_cnt_b1",      32'(cnt_b),       32'd1);
        drive(0, 0, 8'h00, 0, 1);
        tick();
        chk("bp_cnt_b2", 32'(cnt_b), 32'd2);

        // Cross-port independence
        drive(1, 1, 8'h33, 0, 0);
        tick();
        drive(1, 0, 8'h44, 0, 0);
        #1;
        chk("xp_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("xp_b_data",  32'(out_b_data),  32'h44);
        chk("xp_a_data",  32'(out_a_data),  32'h33);
        chk("xp_a_valid", 32'(out_a_valid), 32'd1);
        drive(0, 0, 8'h00, 1, 1);
        tick();
        tick();

        // Throughput from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, W'(8'hA0 + i), 1, 0);
            #1;
            chk("tp_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("tp_a_valid", 32'(out_a_valid), 32'd1);
        end
        drive(0, 1, 8'h00, 1, 0);
        tick();
        chk("tp_cnt_a", 32'(cnt_a), 32'd10);

        // Wrap of the port-B counter
        ca_start = dlv_a;
        cb_start = dlv_b;
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, W'($urandom), 0, 1);
            tick();
        end
        drive(0, 0, 8'h00, 0, 1);
        tick();
        chk("wrap_cnt_b", 32'(cnt_b), 32'(cb_start));
        chk("wrap_cnt_a", 32'(cnt_a), 32'(ca_start));

        // Reset mid-stream discards both held beats
        drive(1, 1, 8'h77, 0, 0);
        tick();
        drive(1, 0, 8'h88, 0, 0);
        tick();
        drive(0, 0, 8'h00, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_a_valid", 32'(out_a_valid), 32'd0);
        chk("mr_b_valid", 32'(out_b_valid), 32'd0);
        chk("mr_a_data",  32'(out_a_data),  32'd0);
        chk("mr_b_data",  32'(out_b_data),  32'd0);
        chk("mr_cnt_a",   32'(cnt_a),       32'd0);
        chk("mr_cnt_b",   32'(cnt_b),       32'd0);
        out_a_ready = 1'b1;
        out_b_ready = 1'b1;
        tick();
        chk("mr_no_delivery", 32'(cnt_a) + 32'(cnt_b), 32'd0);

        // Randomized traffic; the source holds an unaccepted offer stable
        m_acc = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || m_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel_a    = $urandom_range(0, 1) == 1;
                in_data  = W'($urandom);
            end
            out_a_ready = ($urandom_range(0, 3) != 0);
            out_b_ready = ($urandom_range(0, 2) != 0);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 8'h00, 1, 1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, WIDTH, the input beat payload.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an input beat is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts the offered beat this cycle.
REQ-007 The block SHALL have port sel_a, input, 1, the route for the offered beat: 1 selects port A, 0 selects port B.
REQ-008 The block SHALL have ports out_a_data (output, WIDTH), out_a_valid (output, 1) and out_a_ready (input, 1), forming output port A.
REQ-009 The block SHALL have ports out_b_data (output, WIDTH), out_b_valid (output, 1) and out_b_ready (input, 1), forming output port B.
REQ-010 The block SHALL have ports cnt_a and cnt_b, output, 8 each, counting beats delivered on port A and port B respectively.

Function
REQ-011 Each output port SHALL own a one-entry register (valid flag plus WIDTH data) driving out_x_valid and out_x_data directly, with no combinational path from in_data.
REQ-012 in_ready SHALL be combinational: (!out_a_valid || out_a_ready) when sel_a=1; (!out_b_valid || out_b_ready) when sel_a=0; it SHALL NOT depend on in_valid.
REQ-013 An input transfer SHALL occur when in_valid && in_ready; in_data SHALL load into the selected port register at that edge, with out_x_valid=1 from the next cycle (latency 1 cycle).
REQ-014 An output transfer on port x SHALL occur when out_x_valid && out_x_ready; out_x_valid SHALL clear at that edge unless the same port is reloaded in the same cycle.
REQ-015 On a simultaneous drain and load of the same port, the register SHALL take the new beat and out_x_valid SHALL stay 1, sustaining 1 beat/cycle per port.
REQ-016 An input transfer SHALL NOT modify the register or valid of the non-selected port.
REQ-017 While out_x_valid=1 and out_x_ready=0, out_x_data and out_x_valid SHALL hold stable.
REQ-018 When out_x_valid=0, out_x_data SHALL hold its last value.
REQ-019 Beat order within a port SHALL be preserved; relative order across ports is not guaranteed.
REQ-020 cnt_x SHALL increment by 1 on each port-x output transfer and wrap 255 -> 0; no increment on input acceptance.
REQ-021 in_valid=1 with in_ready=0 SHALL leave all state unchanged; the source holds in_data and sel_a stable until accepted.
REQ-022 Ready on the non-selected port SHALL NOT affect in_ready.

Reset
REQ-023 While rst=1 at a rising edge: out_a_valid=0, out_b_valid=0, out_a_data=0, out_b_data=0, cnt_a=0, cnt_b=0.
REQ-024 in_ready SHALL be forced to 0 while rst=1; no input beat is accepted during reset.
REQ-025 Reset asserted mid-operation SHALL discard held beats without delivering them and without counter increments in that cycle.
REQ-026 In the first cycle after rst deasserts, with both ports empty, in_ready SHALL be 1.

Verification
REQ-027 Route A: after reset, in_data=8'h5A, sel_a=1, in_valid=1, out_a_ready=1 for 1 cycle -> next cycle out_a_valid=1, out_a_data=5A, out_b_valid=0; cnt_a=1 one cycle later.
REQ-028 Backpressure: load port B with 8'h11, out_b_ready=0, offer 8'h22 with sel_a=0 -> in_ready=0, out_b_data stays 11; raise out_b_ready -> 22 accepted the same cycle, 11 then 22 delivered back-to-back.
REQ-029 Cross-port independence: port A full with out_a_ready=0, offer a beat with sel_a=0 -> in_ready=1, beat lands on B, port A unchanged.
REQ-030 Throughput: 10 consecutive beats to A with out_a_ready=1 constantly -> one accept per cycle, out_a_valid continuously 1, cnt_a=10.
REQ-031 Wrap: 256 port-B transfers -> cnt_b returns to 0; cnt_a unchanged.
REQ-032 Reset mid-stream: both ports valid, ready=0, assert rst 1 cycle -> both valids 0, data 0, counts 0, and no beat delivered.
